// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: one shared programmable tick prescaler feeding NCH
// independent countdown channels. Each channel expires after a programmed
// number of ticks. Expiry raises a one-cycle expire pulse and a sticky
// irq_pend bit.
module tick_timer_ctrl #(
  parameter int NCH = 4,
  parameter int DIVW = 27,
  parameter logic [DIVW-1:0] DEFAULT_DIV = DIVW'(49_999_999),
  parameter int TW = 16,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_en,
  input  logic            cfg_we,
  input  logic [DIVW-1:0] cfg_div,
  output logic            cfg_err,
  input  logic            arm_valid,
  input  logic [CHW-1:0]  arm_ch,
  input  logic [TW-1:0]   arm_ticks,
  output logic            arm_ready,
  input  logic [NCH-1:0]  cancel,
  input  logic [NCH-1:0]  irq_clr,
  output logic            tick,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  expire,
  output logic [NCH-1:0]  irq_pend,
  output logic            irq
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // arm_ch can address slots beyond NCH when NCH is not a power of two.
  // Those phantom slots are treated as permanently busy so they never accept.
  localparam int NPAD = 1 << CHW;

  logic [DIVW-1:0] div_reg;
  logic [DIVW-1:0] presc_reg;
  logic            tick_reg;
  logic            cfg_err_reg;
  logic [NCH-1:0]  irq_pend_reg;
  logic [NPAD-1:0] busy_pad;
  logic            cfg_ok;

  // A new divide value is only accepted while no channel is counting.
  // Otherwise running timeouts would silently change length.
  assign cfg_ok = cfg_we & ~(|busy);

  // Prescaler and divide register. An accepted config write restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg     <= DEFAULT_DIV;
      presc_reg   <= '0;
      tick_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we & (|busy);
      if (cfg_ok) begin
        div_reg   <= cfg_div;
        presc_reg <= '0;
        tick_reg  <= 1'b0;
      end else if (tick_en) begin
        if (presc_reg == div_reg) begin
          presc_reg <= '0;
          tick_reg  <= 1'b1;
        end else begin
          presc_reg <= presc_reg + DIVW'(1);
          tick_reg  <= 1'b0;
        end
      end else begin
        tick_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_pad
      if (gi < NCH) begin : g_real
        assign busy_pad[gi] = busy[gi];
      end else begin : g_phantom
        assign busy_pad[gi] = 1'b1;
      end
    end
  endgenerate

  assign arm_ready = ~busy_pad[arm_ch];

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      ch_state_t     state_reg, state_next;
      logic [TW-1:0] remaining_reg, remaining_next;
      logic          expire_reg, expire_next;
      logic          arm_hit;

      assign arm_hit = arm_valid & arm_ready & (arm_ch == CHW'(gi));

      // Channel state, remaining tick count and registered expiry pulse.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg     <= IDLE;
          remaining_reg <= '0;
          expire_reg    <= 1'b0;
        end else begin
          state_reg     <= state_next;
          remaining_reg <= remaining_next;
          expire_reg    <= expire_next;
        end
      end

      // Next-state logic. Cancel is checked before the tick so it suppresses a coincident expiry.
      always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        expire_next    = 1'b0;
        case (state_reg)
          IDLE: begin
            // A tick in the arming cycle is ignored because the channel is still IDLE.
            if (arm_hit) begin
              if (arm_ticks == '0) begin
                expire_next = 1'b1;
              end else begin
                state_next     = RUN;
                remaining_next = arm_ticks;
              end
            end
          end
          RUN: begin
            if (cancel[gi]) begin
              state_next     = IDLE;
              remaining_next = '0;
            end else if (tick_reg) begin
              if (remaining_reg == TW'(1)) begin
                state_next     = IDLE;
                remaining_next = '0;
                expire_next    = 1'b1;
              end else begin
                remaining_next = remaining_reg - TW'(1);
              end
            end
          end
          default: begin
            state_next     = IDLE;
            remaining_next = '0;
          end
        endcase
      end

      assign busy[gi]   = (state_reg == RUN);
      assign expire[gi] = expire_reg;
    end
  endgenerate

  // Sticky expiry flags. A new expiry wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pend_reg <= '0;
    end else begin
      irq_pend_reg <= (irq_pend_reg & ~irq_clr) | expire;
    end
  end

  assign tick     = tick_reg;
  assign cfg_err  = cfg_err_reg;
  assign irq_pend = irq_pend_reg;
  assign irq      = |irq_pend_reg;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl with a divide value of 3 (tick every 4 clocks).
// Inputs change on the falling edge, and outputs are checked at the falling edge.
module tb_tick_timer_ctrl;

  localparam int NCH  = 4;
  localparam int DIVW = 27;
  localparam int TW   = 16;
  localparam int CHW  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            tick_en;
  logic            cfg_we;
  logic [DIVW-1:0] cfg_div;
  logic            cfg_err;
  logic            arm_valid;
  logic [CHW-1:0]  arm_ch;
  logic [TW-1:0]   arm_ticks;
  logic            arm_ready;
  logic [NCH-1:0]  cancel;
  logic [NCH-1:0]  irq_clr;
  logic            tick;
  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  expire;
  logic [NCH-1:0]  irq_pend;
  logic            irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  tick_timer_ctrl #(
    .NCH(NCH),
    .DIVW(DIVW),
    .DEFAULT_DIV(27'd3),
    .TW(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick_en(tick_en),
    .cfg_we(cfg_we),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .arm_valid(arm_valid),
    .arm_ch(arm_ch),
    .arm_ticks(arm_ticks),
    .arm_ready(arm_ready),
    .cancel(cancel),
    .irq_clr(irq_clr),
    .tick(tick),
    .busy(busy),
    .expire(expire),
    .irq_pend(irq_pend),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to falling edge number n after reset release.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic arm(input logic [CHW-1:0] ch, input logic [TW-1:0] t);
    arm_valid = 1'b1;
    arm_ch    = ch;
    arm_ticks = t;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    tick_en   = 1'b0;
    cfg_we    = 1'b0;
    cfg_div   = '0;
    arm_valid = 1'b0;
    arm_ch    = '0;
    arm_ticks = '0;
    cancel    = '0;
    irq_clr   = '0;

    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_expire", expire, 0);
    chk("rst_irq_pend", irq_pend, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_div", dut.div_reg, 3);
    chk("rst_presc", dut.presc_reg, 0);

    reset   = 1'b1;
    tick_en = 1'b1;
    cyc     = 0;

    // 1) Free-running prescaler: the tick is visible on every 4th cycle.
    for (int k = 1; k <= 8; k++) begin
      goto(k);
      chk($sformatf("tick_c%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      if (k == 3) chk("presc_top", dut.presc_reg, 3);
      if (k == 4) chk("presc_wrap", dut.presc_reg, 0);
    end

    // 2) Arm ch0 for 5 ticks; the tick in the arming cycle is not counted.
    arm(0, 5);
    goto(9);
    arm_valid = 1'b0;
    chk("arm0_busy", busy, 4'b0001);
    goto(28);
    chk("ch0_5th_tick", tick, 1);
    chk("ch0_busy_pre", busy, 4'b0001);
    chk("ch0_no_early_exp", expire, 0);
    goto(29);
    chk("ch0_expire", expire, 4'b0001);
    chk("ch0_busy_done", busy, 0);
    goto(30);
    chk("ch0_expire_1cyc", expire, 0);
    chk("ch0_irq_pend", irq_pend, 4'b0001);
    chk("ch0_irq", irq, 1);

    // 3) Arm ch1 for 3 ticks, then cancel during the 3rd tick. Also clear irq_pend[0].
    arm(1, 3);
    goto(31);
    arm_valid = 1'b0;
    irq_clr   = 4'b0001;
    chk("arm1_busy", busy, 4'b0010);
    goto(32);
    irq_clr = '0;
    chk("clr0_irq_pend", irq_pend, 0);
    chk("clr0_irq", irq, 0);
    goto(40);
    chk("ch1_3rd_tick", tick, 1);
    chk("ch1_busy_pre", busy, 4'b0010);
    cancel = 4'b0010;
    goto(41);
    cancel = '0;
    chk("cancel_busy", busy, 0);
    chk("cancel_no_exp", expire, 0);

    // 4) A zero-tick arm on ch2 expires at once without going busy.
    arm(2, 0);
    goto(42);
    arm_valid = 1'b0;
    chk("zero_expire", expire, 4'b0100);
    chk("zero_busy", busy, 0);
    goto(43);
    chk("zero_expire_1cyc", expire, 0);
    chk("zero_irq_pend", irq_pend, 4'b0100);
    arm(0, 3);
    goto(44);
    arm_valid = 1'b0;
    chk("arm0b_busy", busy, 4'b0001);
    arm_ch = 0;
    #1 chk("ready_busy_ch", arm_ready, 0);
    arm_ch = 3;
    #1 chk("ready_idle_ch", arm_ready, 1);
    arm(0, 1);  // ch0 must not accept this while it is still running
    goto(45);
    arm_valid = 1'b0;

    // 5) A config write while ch0 is busy is rejected.
    cfg_we  = 1'b1;
    cfg_div = 27'd9;
    goto(46);
    cfg_we = 1'b0;
    chk("cfg_err_busy", cfg_err, 1);
    goto(47);
    chk("cfg_err_1cyc", cfg_err, 0);
    chk("div_kept", dut.div_reg, 3);
    goto(48);
    chk("period_kept_48", tick, 1);
    chk("ch0b_busy_48", busy, 4'b0001);
    goto(52);
    chk("period_kept_52", tick, 1);
    chk("ch0b_no_early_exp", expire, 0);
    goto(53);
    chk("ch0b_expire", expire, 4'b0001);
    irq_clr = 4'b0101;  // clear coincides with ch0 expiry and ch2's stale flag
    goto(54);
    irq_clr = '0;
    chk("set_beats_clr", irq_pend, 4'b0001);
    chk("set_beats_clr_irq", irq, 1);
    chk("all_idle", busy, 0);
    cfg_we  = 1'b1;
    cfg_div = 27'd9;
    goto(55);
    cfg_we = 1'b0;
    chk("cfg_ok_no_err", cfg_err, 0);
    for (int k = 55; k <= 75; k++) begin
      goto(k);
      chk($sformatf("div9_tick_c%0d", k), tick, (k == 65 || k == 75) ? 1 : 0);
    end

    // 6) Arm every channel, then assert reset in the middle of the count.
    arm(0, 100);
    goto(76);
    arm(1, 100);
    goto(77);
    arm(2, 100);
    goto(78);
    arm(3, 100);
    goto(79);
    arm_valid = 1'b0;
    chk("all_busy", busy, 4'b1111);
    goto(80);
    reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_expire", expire, 0);
    chk("async_irq_pend", irq_pend, 0);
    chk("async_irq", irq, 0);
    chk("async_tick", tick, 0);
    chk("async_div", dut.div_reg, 3);
    goto(82);
    reset = 1'b1;
    goto(85);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_expire", expire, 0);
    goto(86);
    chk("post_rst_tick_div3", tick, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
